pwm_ramp_sequencer: RTL

//  Start/stop sequencer and duty-ramp controller for one pwm channel. Drives the pwm

---
 rtl/pwm_ramp_sequencer_if.sv | 33 +++
 rtl/pwm_ramp_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// Handshake/bus bundle between the register block, the ramp sequencer and the pwm instance.
// Names are from the sequencer's point of view: i_* into the sequencer, o_* out of it.
interface pwm_ramp_sequencer_if #(
  parameter int W = 32
);
  logic         i_start;
  logic         i_stop;
  logic         i_fault;
  logic         i_fault_clear;
  logic [W-1:0] i_period_in;
  logic [W-1:0] i_target_duty;
  logic [W-1:0] i_step;
  logic         i_ovf;
  logic [W-1:0] o_pwm_period;
  logic [W-1:0] o_pwm_duty;
  logic         o_pwm_en;
  logic         o_pwm_rst;
  logic         o_ovf_en;
  logic [2:0]   o_state;
  logic         o_busy;
  logic         o_at_target;

  // Register side drives commands and observes status.
  modport master (
    output i_start, i_stop, i_fault, i_fault_clear, i_period_in, i_target_duty, i_step, i_ovf,
    input  o_pwm_period, o_pwm_duty, o_pwm_en, o_pwm_rst, o_ovf_en, o_state, o_busy, o_at_target
  );

  modport slave (
    input  i_start, i_stop, i_fault, i_fault_clear, i_period_in, i_target_duty, i_step, i_ovf,
    output o_pwm_period, o_pwm_duty, o_pwm_en, o_pwm_rst, o_ovf_en, o_state, o_busy, o_at_target
  );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Soft start/stop and duty ramp controller for one pwm channel, timed by the pwm ovf pulse.
// Optional macro PWM_SEQ_FAULT_LATCH_EN makes FAULT sticky until fault_clear with fault low.
module pwm_ramp_sequencer #(
  parameter int W       = 32,
  parameter int PRE_CYC = 4
) (
  input  logic               clk,
  input  logic               reset,
  pwm_ramp_sequencer_if.slave bus
);
  localparam int CW = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRELOAD  = 3'd1,
    S_RAMP     = 3'd2,
    S_RUN      = 3'd3,
    S_STOPPING = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [W-1:0]  r_duty, w_nxt_duty;
  logic [W-1:0]  r_period, w_nxt_period;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          r_en, r_rst, r_ovf_en, r_busy, r_at_target;

  logic [W-1:0]  w_tgt, w_up, w_dn, w_ramp, w_stop;
  logic [W:0]    w_sum;
  logic          w_active;

  // Ramp arithmetic: the up-sum keeps a carry bit so a large step saturates at tgt.
  always_comb begin
    w_tgt = (bus.i_target_duty > bus.i_period_in) ? bus.i_period_in : bus.i_target_duty;
    w_sum = {1'b0, r_duty} + {1'b0, bus.i_step};
    w_up  = (w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[W-1:0];
    w_dn  = (bus.i_step >= (r_duty - w_tgt)) ? w_tgt : (r_duty - bus.i_step);
    if (bus.i_step == '0)     w_ramp = w_tgt;
    else if (r_duty < w_tgt)  w_ramp = w_up;
    else                      w_ramp = w_dn;
    if ((bus.i_step == '0) || (bus.i_step >= r_duty)) w_stop = '0;
    else                                              w_stop = r_duty - bus.i_step;
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_duty   = r_duty;
    w_nxt_period = r_period;
    w_nxt_cnt    = r_cnt;
    if (bus.i_fault) begin
      w_nxt_state = S_FAULT;
      w_nxt_duty  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nxt_duty = '0;
          if (bus.i_start) begin
            w_nxt_state  = S_PRELOAD;
            w_nxt_period = bus.i_period_in;
            w_nxt_cnt    = '0;
          end
        end
        S_PRELOAD: begin
          w_nxt_duty = '0;
          if (r_cnt == CW'(PRE_CYC - 1)) w_nxt_state = S_RAMP;
          else                           w_nxt_cnt   = r_cnt + 1'b1;
        end
        S_RAMP: begin
          if (bus.i_stop)             w_nxt_state = S_STOPPING;
          else if (r_duty == w_tgt)   w_nxt_state = S_RUN;
          else if (bus.i_ovf)         w_nxt_duty  = w_ramp;
        end
        S_RUN: begin
          if (bus.i_stop)             w_nxt_state = S_STOPPING;
          else if (r_duty != w_tgt)   w_nxt_state = S_RAMP;
          else if (bus.i_ovf)         w_nxt_period = bus.i_period_in;
        end
        S_STOPPING: begin
          if (bus.i_ovf) begin
            if (r_duty == '0) w_nxt_state = S_IDLE;
            else              w_nxt_duty  = w_stop;
          end
        end
        S_FAULT: begin
          w_nxt_duty = '0;
`ifdef PWM_SEQ_FAULT_LATCH_EN
          if (bus.i_fault_clear) w_nxt_state = S_IDLE;
`else
          w_nxt_state = S_IDLE;
`endif
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

`ifndef PWM_SEQ_FAULT_LATCH_EN
  logic w_unused;
  assign w_unused = bus.i_fault_clear;
`endif

  assign w_active = (w_nxt_state == S_RAMP) || (w_nxt_state == S_RUN) ||
                    (w_nxt_state == S_STOPPING);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_period    <= '0;
      r_cnt       <= '0;
      r_en        <= 1'b0;
      r_rst       <= 1'b1;
      r_ovf_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_at_target <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_duty      <= w_nxt_duty;
      r_period    <= w_nxt_period;
      r_cnt       <= w_nxt_cnt;
      r_en        <= w_active;
      r_rst       <= !w_active;
      r_ovf_en    <= w_active;
      r_busy      <= (w_nxt_state != S_IDLE) && (w_nxt_state != S_FAULT);
      r_at_target <= (w_nxt_state == S_RUN);
    end
  end

  assign bus.o_pwm_period = r_period;
  assign bus.o_pwm_duty   = r_duty;
  assign bus.o_pwm_en     = r_en;
  assign bus.o_pwm_rst    = r_rst;
  assign bus.o_ovf_en     = r_ovf_en;
  assign bus.o_state      = r_state;
  assign bus.o_busy       = r_busy;
  assign bus.o_at_target  = r_at_target;
endmodule
